upa2_mc: RTL and testbench

//   Multi-channel G.726 a2 predictor-coefficient update (UPA2 + LIMC), time-multiplexed over CHANNELS.

---
 rtl/upa2_mc_if.sv | 29 ++
 rtl/upa2_mc.sv | 156 +++++++++++++++
 tb/tb_upa2_mc.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upa2_mc_if.sv
// Request/result bus for the multi-channel a2 update block.
// master drives requests and consumes results; slave is the update block.
interface upa2_mc_if #(
    parameter int CH_W = 2
) ();
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic            in_init;
    logic            pk0;
    logic            pk1;
    logic            pk2;
    logic            sigpk;
    logic [15:0]     a1;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [15:0]     a2p;

    modport master (
        output in_valid, in_ch, in_init, pk0, pk1, pk2, sigpk, a1, out_ready,
        input  in_ready, out_valid, out_ch, a2p
    );

    modport slave (
        input  in_valid, in_ch, in_init, pk0, pk1, pk2, sigpk, a1, out_ready,
        output in_ready, out_valid, out_ch, a2p
    );
endinterface

// File: rtl/upa2_mc.sv
// Multi-channel G.726 a2 predictor-coefficient update (UPA2 + LIMC).
// Stage 1 registers the channel, init flag and gradient term UGA2.
// Stage 2 reads the channel's a2, applies gradient and leakage, limits,
// writes the store back and presents the result.
module upa2_mc #(
    parameter int          CHANNELS    = 4,
    parameter int          CH_W        = 2,
    parameter bit          LIMIT_EN    = 1'b1,
    parameter logic [15:0] A2_MIN      = 16'hD000,
    parameter logic [15:0] A2_MAX      = 16'h3000,
    parameter int          SCAN_CHAINS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    upa2_mc_if.slave               bus,
    input  logic                   scan_enable,
    input  logic                   test_mode,
    input  logic [SCAN_CHAINS-1:0] scan_in,
    output logic [SCAN_CHAINS-1:0] scan_out
);

    localparam logic [CH_W:0] CH_LIMIT = CHANNELS[CH_W:0];

    // Pipeline state
    logic            s1_valid_q, s1_valid_d;
    logic [CH_W-1:0] s1_ch_q,    s1_ch_d;
    logic            s1_init_q,  s1_init_d;
    logic [15:0]     s1_uga2_q,  s1_uga2_d;
    logic            out_valid_q, out_valid_d;
    logic [CH_W-1:0] out_ch_q,    out_ch_d;
    logic [15:0]     a2p_q,       a2p_d;
    logic [15:0]     store_q [CHANNELS];
    logic [15:0]     store_d [CHANNELS];

    // Combinational datapath
    logic        advance;
    logic        pks1, pks2;
    logic [15:0] a1s;
    logic [16:0] uga2a, fa1, fa, uga2b;
    logic [15:0] uga2_in;
    logic        s1_in_range;
    logic [15:0] a2_rd, ula2, ua2, a2t, a2_lim, a2p_new;

    // The whole pipeline moves together unless a result is waiting to be taken.
    assign advance      = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.a2p       = a2p_q;

    // Scan chains are stitched at DFT insertion; the RTL view is inert.
    assign scan_out = '0;

    logic unused_bits;
    assign unused_bits = ^{scan_enable, test_mode, scan_in, uga2b[6:0], a1s[15]};

    // Stage-1 gradient term UGA2 from sign correlations and the clipped a1.
    // NOTE: every always_comb output gets a value on every path (defaults or
    // full if/else), otherwise synthesis infers a latch.
    always_comb begin
        pks1 = bus.pk0 ^ bus.pk1;
        pks2 = bus.pk0 ^ bus.pk2;
        uga2a = pks2 ? 17'h1C000 : 17'h04000;
        if ($signed(bus.a1) > $signed(16'h1FFF)) begin
            a1s = 16'h1FFF;
        end else if ($signed(bus.a1) < $signed(16'hE001)) begin
            a1s = 16'hE001;
        end else begin
            a1s = bus.a1;
        end
        // a1s fits in 14 bits plus sign, so 4*a1s is exact in 17 bits.
        fa1   = {a1s[14:0], 2'b00};
        fa    = pks1 ? fa1 : 17'h0 - fa1;
        uga2b = uga2a + fa;
        uga2_in = bus.sigpk ? 16'h0000 : {{6{uga2b[16]}}, uga2b[16:7]};
    end

    // Stage-2 coefficient update: a2 + UGA2 - (a2 >>> 7), then limit.
    always_comb begin
        s1_in_range = ({1'b0, s1_ch_q} < CH_LIMIT);
        a2_rd  = s1_in_range ? store_q[s1_ch_q] : 16'h0000;
        ula2   = 16'h0000 - {{7{a2_rd[15]}}, a2_rd[15:7]};
        ua2    = s1_uga2_q + ula2;
        a2t    = a2_rd + ua2;
        a2_lim = a2t;
        if (LIMIT_EN) begin
            if ($signed(a2t) > $signed(A2_MAX)) begin
                a2_lim = A2_MAX;
            end else if ($signed(a2t) < $signed(A2_MIN)) begin
                a2_lim = A2_MIN;
            end
        end
        a2p_new = (s1_init_q || !s1_in_range) ? 16'h0000 : a2_lim;
    end

    // Next-state: hold everything on stall, otherwise shift both stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ch_d     = s1_ch_q;
        s1_init_d   = s1_init_q;
        s1_uga2_d   = s1_uga2_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        a2p_d       = a2p_q;
        store_d     = store_q;
        if (advance) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_ch_d   = bus.in_ch;
                s1_init_d = bus.in_init;
                s1_uga2_d = uga2_in;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_ch_d = s1_ch_q;
                a2p_d    = a2p_new;
                // The write lands before the next stage-2 read, so a
                // same-channel follower sees this result without forwarding.
                if (s1_in_range) begin
                    store_d[s1_ch_q] = a2p_new;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_init_q   <= 1'b0;
            s1_uga2_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            a2p_q       <= '0;
            // NOTE: the coefficient store is a small register file and must
            // come up at zero like a codec reset, so it is reset explicitly
            // rather than mapped to an uninitialised RAM.
            for (int i = 0; i < CHANNELS; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_init_q   <= s1_init_d;
            s1_uga2_q   <= s1_uga2_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            a2p_q       <= a2p_d;
            store_q     <= store_d;
        end
    end

endmodule

// File: tb/tb_upa2_mc.sv
// Self-checking bench for upa2_mc: directed table, multi-cycle corner
// sequences and randomized traffic against a behavioural coefficient model.
module tb_upa2_mc;
    localparam int CHANNELS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_enable, test_mode;
    logic [4:0] scan_in, scan_out;

    always #5 clk = ~clk;

    upa2_mc_if #(.CH_W(2)) bus ();

    upa2_mc dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_in     (scan_in),
        .scan_out    (scan_out)
    );

    typedef struct {
        logic [1:0]  ch;
        logic        init, pk0, pk1, pk2, sigpk;
        logic [15:0] a1;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] a2p;
        bit          has_tbl;
        logic [15:0] tbl;
    } exp_t;

    exp_t        exp_q[$];
    int          model_a2 [CHANNELS];
    logic [15:0] last_a2p [CHANNELS];
    int          checks = 0;
    int          failures = 0;
    int          out_count = 0;
    bit          over_hi = 0;
    bit          under_lo = 0;
    bit          rdy_rand = 0;
    vec_t        tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // New a2 from the codec rules in plain integer arithmetic.
    function automatic int model_step(int a2, logic init, logic p0, logic p1, logic p2,
                                      logic sg, logic [15:0] a1);
        int a1s, ugb, uga2, n;
        if (init) return 0;
        a1s = $signed(a1);
        if (a1s > 8191) a1s = 8191;
        if (a1s < -8191) a1s = -8191;
        ugb  = ((p0 ^ p2) ? -16384 : 16384) + ((p0 ^ p1) ? 4 * a1s : -4 * a1s);
        uga2 = sg ? 0 : (ugb >>> 7);
        n    = a2 + uga2 - (a2 >>> 7);
        if (n > 12288) n = 12288;
        if (n < -12288) n = -12288;
        return n;
    endfunction

    // Result monitor: every consumed result is matched against the model queue.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got ch=%0d a2p=%h, expected no result", bus.out_ch, bus.a2p);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_ch", 32'(bus.out_ch), 32'(e.ch));
                check("a2p_model", 32'(bus.a2p), 32'(e.a2p));
                if (e.has_tbl) check("a2p_table", 32'(bus.a2p), 32'(e.tbl));
            end
            out_count++;
            last_a2p[bus.out_ch] = bus.a2p;
            if (bus.out_ch == 2'd2 && $signed(bus.a2p) > $signed(16'h3000)) over_hi = 1;
            if (bus.out_ch == 2'd1 && $signed(bus.a2p) < $signed(16'hD000)) under_lo = 1;
        end
    end

    // Randomized result back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request (called just after a rising edge) and hold it until accepted.
    task automatic send(input logic [1:0] ch, input logic init, input logic p0, input logic p1,
                        input logic p2, input logic sg, input logic [15:0] a1,
                        input bit has_tbl, input logic [15:0] tv);
        bit   ok;
        exp_t e;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.in_init  = init;
        bus.pk0      = p0;
        bus.pk1      = p1;
        bus.pk2      = p2;
        bus.sigpk    = sg;
        bus.a1       = a1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_a2[ch] = model_step(model_a2[ch], init, p0, p1, p2, sg, a1);
                e.ch      = ch;
                e.a2p     = 16'(model_a2[ch]);
                e.has_tbl = has_tbl;
                e.tbl     = tv;
                exp_q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_accept ch=%0d: in_ready stayed low, expected acceptance within 200 cycles", ch);
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < CHANNELS; i++) model_a2[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_ch = 0; bus.in_init = 0;
        bus.pk0 = 0; bus.pk1 = 0; bus.pk2 = 0; bus.sigpk = 0;
        bus.a1 = 0; bus.out_ready = 1;
        scan_enable = 0; test_mode = 0; scan_in = 5'h15;
        for (int i = 0; i < CHANNELS; i++) last_a2p[i] = 16'h0;

        tbl[0]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0080};
        tbl[1]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00FF};
        tbl[2]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h00FE};
        tbl[3]  = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFF80};
        tbl[4]  = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h00FD};
        tbl[5]  = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1FFF, 16'h017F};
        tbl[6]  = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1FFF, 16'h02FC};
        tbl[7]  = '{2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h017F};
        tbl[8]  = '{2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h00FD};
        tbl[9]  = '{2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000};
        tbl[10] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0080};

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_a2p", 32'(bus.a2p), 32'd0);
        check("rst_out_ch", 32'(bus.out_ch), 32'd0);
        check("rst_scan_out", 32'(scan_out), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        do_reset();

        // Init request and latency
        send(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4321, 1'b1, 16'h0000);
        @(negedge clk);
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("init_a2p", 32'(bus.a2p), 32'd0);
        check("init_ch", 32'(bus.out_ch), 32'd0);
        @(posedge clk);
        #1;
        drain("init");

        // Directed table, issued back-to-back
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].ch, tbl[i].init, tbl[i].pk0, tbl[i].pk1, tbl[i].pk2,
                 tbl[i].sigpk, tbl[i].a1, 1'b1, tbl[i].exp);
        end
        drain("table");

        // Positive saturation on ch2
        repeat (64) send(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1FFF, 1'b0, 16'h0);
        drain("sat_hi");
        check("ch2_saturated", 32'(last_a2p[2]), 32'h3000);
        check("ch2_never_above", 32'(over_hi), 32'd0);

        // Negative saturation on ch1
        repeat (64) send(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1FFF, 1'b0, 16'h0);
        drain("sat_lo");
        check("ch1_saturated", 32'(last_a2p[1]), 32'hD000);
        check("ch1_never_below", 32'(under_lo), 32'd0);

        // Back-pressure: four requests against a stalled output
        begin : stall_test
            int c0;
            c0 = out_count;
            bus.out_ready = 1'b0;
            fork
                begin : stall_drive
                    for (int k = 0; k < 4; k++) begin
                        send(2'(k), 1'b0, k[0], 1'b0, k[1], 1'b0, 16'(16'h0400 * k), 1'b0, 16'h0);
                    end
                end
                begin : stall_watch
                    bit          seen;
                    logic [15:0] h_a2p;
                    logic [1:0]  h_ch;
                    seen = 0;
                    for (int k = 0; k < 50; k++) begin
                        @(negedge clk);
                        if (bus.out_valid) begin
                            seen = 1;
                            break;
                        end
                    end
                    check("stall_fill", 32'(seen), 32'd1);
                    h_a2p = bus.a2p;
                    h_ch  = bus.out_ch;
                    repeat (4) begin
                        @(negedge clk);
                        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                        check("stall_a2p_stable", 32'(bus.a2p), 32'(h_a2p));
                        check("stall_ch_stable", 32'(bus.out_ch), 32'(h_ch));
                    end
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'b1;
                end
            join
            drain("stall");
            check("stall_count", 32'(out_count - c0), 32'd4);
        end

        // Asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        send(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1FFF, 1'b0, 16'h0);
        send(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1FFF, 1'b0, 16'h0);
        check("midrst_pre_full", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_a2p", 32'(bus.a2p), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        do_reset();
        send(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080);
        send(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0080);
        drain("post_reset");

        // Randomized traffic with random back-pressure
        rdy_rand = 1;
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  ch;
            logic [15:0] a1;
            ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a1 = 16'($urandom);
                1:       a1 = 16'h1FFE + 16'($urandom_range(0, 3));
                2:       a1 = 16'hDFFF + 16'($urandom_range(0, 3));
                default: a1 = 16'($urandom_range(0, 255)) - 16'd128;
            endcase
            scan_enable = 1'($urandom_range(0, 1));
            test_mode   = 1'($urandom_range(0, 1));
            scan_in     = 5'($urandom);
            send(ch, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), a1, 1'b0, 16'h0);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_rand = 0;
        bus.out_ready = 1'b1;
        drain("random");

        check("scan_out_zero", 32'(scan_out), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
